// File: rtl/bs_pkg.sv
// Shared types and constants for the Black-Scholes pipeline sequencer.
package bs_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ISSUE    = 4'd1,
    S_DRAIN    = 4'd2,
    S_CONV_ACC = 4'd3,
    S_CONV_POW = 4'd4,
    S_COMPLETE = 4'd5
  } bs_state_e;

  localparam logic [3:0] CMD_RUN   = 4'd1;
  localparam logic [3:0] CMD_ACK   = 4'd2;
  localparam logic [3:0] CMD_ABORT = 4'd3;

  localparam int unsigned LAT_ACC  = 45;
  localparam int unsigned LAT_POW  = 50;
  localparam int unsigned LAT_FXFP = 6;

endpackage

// File: rtl/bs_pipe_sequencer_tracker.sv
// Per-sample valid shift register: one bit per in-flight sample, two output
// taps and an all-zero flag used to detect that the pipeline has drained.
module bs_valid_tracker #(
  parameter int unsigned DEPTH = 50,
  parameter int unsigned TAP_A = 45
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_clr,
  input  logic i_in,
  output logic o_tap_a,
  output logic o_tap_b,
  output logic o_zero
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[DEPTH-2:0], i_in};
    end
  end

  assign o_tap_a = r_sr[TAP_A-1];
  assign o_tap_b = r_sr[DEPTH-1];
  assign o_zero  = (r_sr == '0);

endmodule

// File: rtl/bs_pipe_sequencer.sv
// Black-Scholes datapath sequencer: sample issue, drain via valid tracker,
// fixed->float conversion strobes. Optional cycle counter: BS_SEQ_CYCLE_COUNT_EN.
module bs_pipe_sequencer #(
  parameter int unsigned NITER_W  = 32,
  parameter int unsigned LAT_ACC  = bs_pkg::LAT_ACC,
  parameter int unsigned LAT_POW  = bs_pkg::LAT_POW,
  parameter int unsigned LAT_FXFP = bs_pkg::LAT_FXFP
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [3:0]         cmd,
  input  logic [NITER_W-1:0] niter,
  input  logic               grn_valid,
  output logic               grn_ready,
  output logic               acc_clr,
  output logic               acc_en,
  output logic               pow_acc_en,
  output logic               fx_sel,
  output logic               acc_dout_we,
  output logic               pow_dout_we,
  output logic [3:0]         status,
  output logic [NITER_W-1:0] issued,
  output logic [31:0]        run_cycles
);
  import bs_pkg::*;

  localparam int unsigned CW = $clog2(LAT_FXFP + 2);

  bs_state_e          r_state, w_next;
  logic [NITER_W-1:0] r_niter, r_issued;
  logic [CW-1:0]      r_cnt;
  logic               r_acc_clr;
  logic               w_run, w_ack, w_abort, w_accept, w_last_accept;
  logic               w_last_cnt, w_trk_zero, w_in_conv;

  assign w_run         = (cmd == CMD_RUN);
  assign w_ack         = (cmd == CMD_ACK);
  assign w_abort       = (cmd == CMD_ABORT) && (r_state != S_IDLE);
  assign grn_ready     = (r_state == S_ISSUE);
  assign w_accept      = grn_valid & grn_ready;
  assign w_last_accept = w_accept && ((r_issued + NITER_W'(1)) == r_niter);
  assign w_last_cnt    = (r_cnt == CW'(LAT_FXFP));
  assign w_in_conv     = (r_state == S_CONV_ACC) || (r_state == S_CONV_POW);

  bs_valid_tracker #(
    .DEPTH (LAT_POW),
    .TAP_A (LAT_ACC)
  ) u_tracker (
    .clk     (clk),
    .nreset  (nreset),
    .i_clr   (w_abort),
    .i_in    (w_accept),
    .o_tap_a (acc_en),
    .o_tap_b (pow_acc_en),
    .o_zero  (w_trk_zero)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_run) w_next = (niter == '0) ? S_CONV_ACC : S_ISSUE;
      S_ISSUE:    if (w_last_accept) w_next = S_DRAIN;
      S_DRAIN:    if (w_trk_zero) w_next = S_CONV_ACC;
      S_CONV_ACC: if (w_last_cnt) w_next = S_CONV_POW;
      S_CONV_POW: if (w_last_cnt) w_next = S_COMPLETE;
      S_COMPLETE: if (w_ack) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // acc_clr is registered from the next state so it reads 0 while in reset
  // and rises on the first clock spent in IDLE.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_niter   <= '0;
      r_issued  <= '0;
      r_cnt     <= '0;
      r_acc_clr <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_acc_clr <= (w_next == S_IDLE);
      if (r_state == S_IDLE && w_run) begin
        r_niter  <= niter;
        r_issued <= '0;
      end else if (w_abort) begin
        r_issued <= '0;
      end else if (w_accept && (r_issued != r_niter)) begin
        r_issued <= r_issued + NITER_W'(1);
      end
      if (w_abort || (w_next != r_state)) begin
        r_cnt <= '0;
      end else if (w_in_conv) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign acc_clr     = r_acc_clr;
  assign fx_sel      = (r_state == S_CONV_POW) || (r_state == S_COMPLETE);
  assign acc_dout_we = (r_state == S_CONV_ACC) && w_last_cnt && !w_abort;
  assign pow_dout_we = (r_state == S_CONV_POW) && w_last_cnt && !w_abort;
  assign status      = r_state;
  assign issued      = r_issued;

`ifdef BS_SEQ_CYCLE_COUNT_EN
  logic [31:0] r_run_cycles;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_run_cycles <= '0;
    end else if (r_state == S_IDLE && w_run) begin
      r_run_cycles <= '0;
    end else if (r_state != S_IDLE && r_state != S_COMPLETE) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end
  end

  assign run_cycles = r_run_cycles;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: doc/bs_pipe_sequencer.md
Name: bs_pipe_sequencer

Overview:
- Sequences the Black-Scholes floating-point datapath: Gaussian sample issue → multiply/exp/sub/mult → fixed-point accumulate.
- Replaces the fixed cycle-count completion with a per-sample valid tracker, so GRN bubbles and any sample count are handled exactly.
- Drives accumulator enables, the fixed→float converter select and the result write strobes.
- Sits between the M1 command registers, the GRN generator and the processor datapath.

Parameters:
- NITER_W, 32, width of the sample-count input.
- LAT_ACC, 45, cycles from sample accept to valid const3_mult_conv output.
- LAT_POW, 50, cycles from sample accept to valid pow_conv output; must be ≥ LAT_ACC.
- LAT_FXFP, 6, latency of the fixed→float converter.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- cmd  in  4  1 = RUN, 2 = ACK, 3 = ABORT; all other values ignored.
- niter  in  NITER_W  number of samples; captured in IDLE on RUN.
- grn_valid  in  1  GRN sample available.
- grn_ready  out  1  sequencer accepts a sample this cycle.
- acc_clr  out  1  clear both accumulators.
- acc_en  out  1  add const3_mult_conv_dout into acc.
- pow_acc_en  out  1  add pow_conv_dout into pow_acc.
- fx_sel  out  1  converter input select: 0 = acc, 1 = pow_acc.
- acc_dout_we  out  1  capture converter output into acc_dout.
- pow_dout_we  out  1  capture converter output into pow_acc_dout.
- status  out  4  current state encoding.
- issued  out  NITER_W  number of samples accepted so far.
- run_cycles  out  32  see Optional Feature.

Behaviour:
- Reset values: all outputs 0, state IDLE, valid tracker cleared, counters 0.
- States and encodings: IDLE = 0, ISSUE = 1, DRAIN = 2, CONV_ACC = 3, CONV_POW = 4, COMPLETE = 5.
- IDLE:
  - acc_clr = 1.
  - On RUN: capture niter and clear issued.
  - If niter = 0, go to CONV_ACC. Otherwise go to ISSUE.
- ISSUE:
  - grn_ready = 1.
  - Accept = grn_valid & grn_ready; each accept increments issued.
  - When the accept that makes issued = niter occurs, go to DRAIN next cycle.
- Valid tracker:
  - Shift register of LAT_POW bits; bit 0 loads the accept value every cycle in every state.
  - acc_en = bit[LAT_ACC-1]; pow_acc_en = bit[LAT_POW-1].
  - An accept at cycle t therefore gives acc_en at cycle t+LAT_ACC and pow_acc_en at cycle t+LAT_POW.
  - Bubbles (grn_valid = 0) produce no enables.
- DRAIN: wait until the tracker is all zero, then go to CONV_ACC.
- CONV_ACC:
  - fx_sel = 0; a counter runs for LAT_FXFP+1 cycles.
  - acc_dout_we pulses for 1 cycle on the last count, then go to CONV_POW.
- CONV_POW:
  - fx_sel = 1; same counter, pulsing pow_dout_we.
  - Then go to COMPLETE.
- COMPLETE:
  - Hold all outputs; accumulators are not cleared.
  - ACK → IDLE. RUN is ignored.
- ABORT, in any non-IDLE state:
  - Next state IDLE; tracker and counters cleared.
  - No write strobe pulses.
  - acc_clr asserts on entry to IDLE.
- Commands not valid for the current state are ignored, e.g. ACK outside COMPLETE, RUN outside IDLE.
- niter captured at RUN is stable for the whole run; changes to the niter input mid-run have no effect.
- Asynchronous reset mid-run returns to IDLE immediately with all outputs 0.
- issued saturates at niter; no wrap-around.

Optional Feature:
- Macro BS_SEQ_CYCLE_COUNT_EN.
- Defined: run_cycles counts clocks spent outside IDLE and COMPLETE. It clears on RUN and holds in COMPLETE; a 32-bit wrap is allowed.
- Undefined: run_cycles is tied to 0 and no counter is synthesised.

Decomposition:
- Package bs_pkg:
  - state enum; CMD_RUN, CMD_ACK, CMD_ABORT.
  - Default latency constants LAT_ACC, LAT_POW, LAT_FXFP.
- Sub-module bs_valid_tracker: a parameterised valid shift register with taps and an all-zero flag.

Test Plan:
- Continuous samples: niter = 3, grn_valid held 1, RUN at cycle 0 → accepts at 1–3; acc_en at 46–48; pow_acc_en at 51–53; acc_dout_we then pow_dout_we each 7 cycles apart after drain; status 5; ACK → status 0.
- Bubbles: niter = 2, grn_valid 1,0,0,1 → issued = 2 after 4 ISSUE cycles; acc_en pulses exactly 3 cycles apart.
- Zero samples: niter = 0 → IDLE → CONV_ACC directly; acc_en never asserts; both write strobes pulse once.
- ABORT: ABORT in DRAIN with enables pending → next cycle IDLE; no further acc_en or write strobes; acc_clr = 1.
- Reset mid-run: nreset low during ISSUE → all outputs 0 asynchronously; after release, a RUN with niter = 1 completes normally.
- Ignored commands: ACK during ISSUE and RUN during COMPLETE → no state change.
